// File: rtl/csa_pipe.sv
// csa_pipe: pipelined carry-select adder resolving BLKS_PER_STAGE blocks per stage.
// Define CSA_PIPE_OVF_EN to add the o_ovf signed-overflow output.
module csa_pipe #(
  parameter int WIDTH          = 16,
  parameter int BLK            = 4,
  parameter int BLKS_PER_STAGE = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_add_term1,
  input  logic [WIDTH-1:0] i_add_term2,
  input  logic             i_cin,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
`ifdef CSA_PIPE_OVF_EN
  output logic             o_cout,
  output logic             o_ovf
`else
  output logic             o_cout
`endif
);

  localparam int NBLK = (WIDTH + BLK - 1) / BLK;
  localparam int S    = (NBLK + BLKS_PER_STAGE - 1) / BLKS_PER_STAGE;

  // Stage inputs (st_*), combinational stage results (nx_*), stage registers (*_q)
  logic [WIDTH-1:0] st_a   [S];
  logic [WIDTH-1:0] st_b   [S];
  logic [WIDTH-1:0] st_sum [S];
  logic             st_c   [S];
  logic [WIDTH-1:0] nx_sum [S];
  logic             nx_c   [S];

  logic             v_q    [S];
  logic [WIDTH-1:0] a_q    [S];
  logic [WIDTH-1:0] b_q    [S];
  logic [WIDTH-1:0] sum_q  [S];
  logic             c_q    [S];
`ifdef CSA_PIPE_OVF_EN
  logic             st_cm  [S];
  logic             nx_cm  [S];
  logic             cm_q   [S];
`endif

  logic adv;

  assign adv = !(o_valid && !i_ready);

  always_comb begin
    logic [WIDTH-1:0] s0;
    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] msk;
    logic             c0;
    logic             c1;
    logic             sel;
    int               blk;
    int               pos;
`ifdef CSA_PIPE_OVF_EN
    logic             m0;
    logic             m1;
    m0 = 1'b0;
    m1 = 1'b0;
`endif
    s0  = '0;
    s1  = '0;
    msk = '0;
    c0  = 1'b0;
    c1  = 1'b1;
    sel = 1'b0;
    blk = 0;
    pos = 0;

    st_a[0]   = i_add_term1;
    st_b[0]   = i_add_term2;
    st_sum[0] = '0;
    st_c[0]   = i_cin;
`ifdef CSA_PIPE_OVF_EN
    st_cm[0]  = 1'b0;
`endif
    for (int s = 1; s < S; s++) begin
      st_a[s]   = a_q[s-1];
      st_b[s]   = b_q[s-1];
      st_sum[s] = sum_q[s-1];
      st_c[s]   = c_q[s-1];
`ifdef CSA_PIPE_OVF_EN
      st_cm[s]  = cm_q[s-1];
`endif
    end

    for (int s = 0; s < S; s++) begin
      nx_sum[s] = st_sum[s];
      nx_c[s]   = st_c[s];
`ifdef CSA_PIPE_OVF_EN
      nx_cm[s]  = st_cm[s];
`endif
      for (int k = 0; k < BLKS_PER_STAGE; k++) begin
        blk = s * BLKS_PER_STAGE + k;
        if (blk < NBLK) begin
          // Block 0 ripples from the real carry-in; the others build both speculative sums.
          c0  = (blk == 0) ? nx_c[s] : 1'b0;
          c1  = 1'b1;
          s0  = '0;
          s1  = '0;
          msk = '0;
          for (int j = 0; j < BLK; j++) begin
            pos = blk * BLK + j;
            if (pos < WIDTH) begin
`ifdef CSA_PIPE_OVF_EN
              if (pos == WIDTH - 1) begin
                m0 = c0;
                m1 = c1;
              end
`endif
              msk[pos] = 1'b1;
              s0[pos]  = st_a[s][pos] ^ st_b[s][pos] ^ c0;
              s1[pos]  = st_a[s][pos] ^ st_b[s][pos] ^ c1;
              c0 = (st_a[s][pos] & st_b[s][pos]) | (c0 & (st_a[s][pos] ^ st_b[s][pos]));
              c1 = (st_a[s][pos] & st_b[s][pos]) | (c1 & (st_a[s][pos] ^ st_b[s][pos]));
            end
          end
          sel       = (blk != 0) && nx_c[s];
          nx_sum[s] = (nx_sum[s] & ~msk) | (sel ? s1 : s0);
          nx_c[s]   = sel ? c1 : c0;
`ifdef CSA_PIPE_OVF_EN
          if (blk == NBLK - 1) nx_cm[s] = sel ? m1 : m0;
`endif
        end
      end
    end
  end

  // Whole pipeline advances together; a stalled output freezes every stage.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int s = 0; s < S; s++) begin
        v_q[s]   <= 1'b0;
        a_q[s]   <= '0;
        b_q[s]   <= '0;
        sum_q[s] <= '0;
        c_q[s]   <= 1'b0;
`ifdef CSA_PIPE_OVF_EN
        cm_q[s]  <= 1'b0;
`endif
      end
    end else if (adv) begin
      v_q[0] <= i_valid;
      for (int s = 1; s < S; s++) v_q[s] <= v_q[s-1];
      for (int s = 0; s < S; s++) begin
        a_q[s]   <= st_a[s];
        b_q[s]   <= st_b[s];
        sum_q[s] <= nx_sum[s];
        c_q[s]   <= nx_c[s];
`ifdef CSA_PIPE_OVF_EN
        cm_q[s]  <= nx_cm[s];
`endif
      end
    end
  end

  // Reset forces ready high even if a stalled result is still showing.
  assign o_ready  = adv || i_rst;
  assign o_valid  = v_q[S-1];
  assign o_result = sum_q[S-1];
  assign o_cout   = c_q[S-1];
`ifdef CSA_PIPE_OVF_EN
  assign o_ovf    = cm_q[S-1] ^ c_q[S-1];
`endif

endmodule

// File: tb/tb_csa_pipe.sv
// tb_csa_pipe: directed checks of csa_pipe in a 16/4/2 (S=2) and a 10/4/1 (S=3) configuration.
module tb_csa_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic        a_rst, a_valid, a_oready, a_cin, a_ovalid, a_iready, a_cout;
  logic [15:0] a_t1, a_t2, a_res;
  logic        b_rst, b_valid, b_oready, b_cin, b_ovalid, b_iready, b_cout;
  logic [9:0]  b_t1, b_t2, b_res;
`ifdef CSA_PIPE_OVF_EN
  logic        a_ovf, b_ovf;
`endif

  csa_pipe #(.WIDTH(16), .BLK(4), .BLKS_PER_STAGE(2)) dut_a (
    .i_clk(clk), .i_rst(a_rst), .i_valid(a_valid), .o_ready(a_oready),
    .i_add_term1(a_t1), .i_add_term2(a_t2), .i_cin(a_cin),
    .o_valid(a_ovalid), .i_ready(a_iready), .o_result(a_res),
`ifdef CSA_PIPE_OVF_EN
    .o_cout(a_cout), .o_ovf(a_ovf)
`else
    .o_cout(a_cout)
`endif
  );

  csa_pipe #(.WIDTH(10), .BLK(4), .BLKS_PER_STAGE(1)) dut_b (
    .i_clk(clk), .i_rst(b_rst), .i_valid(b_valid), .o_ready(b_oready),
    .i_add_term1(b_t1), .i_add_term2(b_t2), .i_cin(b_cin),
    .o_valid(b_ovalid), .i_ready(b_iready), .o_result(b_res),
`ifdef CSA_PIPE_OVF_EN
    .o_cout(b_cout), .o_ovf(b_ovf)
`else
    .o_cout(b_cout)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One isolated operation through dut_a (latency 2); pipeline must be empty on entry.
  task automatic apply_stimulus_a(input logic [15:0] x, input logic [15:0] y, input logic c,
                                  input logic [15:0] er, input logic ec, input logic eo,
                                  input string tag);
    a_t1 = x; a_t2 = y; a_cin = c; a_valid = 1'b1; a_iready = 1'b1;
    #1;
    check_output({tag, " ready"}, 32'(a_oready), 32'd1);
    tick();
    a_valid = 1'b0;
    #1;
    check_output({tag, " lat1 valid"}, 32'(a_ovalid), 32'd0);
    tick();
    #1;
    check_output({tag, " valid"}, 32'(a_ovalid), 32'd1);
    check_output({tag, " result"}, 32'(a_res), 32'(er));
    check_output({tag, " cout"}, 32'(a_cout), 32'(ec));
`ifdef CSA_PIPE_OVF_EN
    check_output({tag, " ovf"}, 32'(a_ovf), 32'(eo));
`else
    if (eo === 1'bx) $display("[TB] %s has undefined overflow expectation", tag);
`endif
    tick();
    #1;
    check_output({tag, " drained"}, 32'(a_ovalid), 32'd0);
  endtask

  // One isolated operation through dut_b (latency 3).
  task automatic apply_stimulus_b(input logic [9:0] x, input logic [9:0] y, input logic c,
                                  input logic [9:0] er, input logic ec, input string tag);
    b_t1 = x; b_t2 = y; b_cin = c; b_valid = 1'b1; b_iready = 1'b1;
    tick();
    b_valid = 1'b0;
    #1;
    check_output({tag, " lat1 valid"}, 32'(b_ovalid), 32'd0);
    tick();
    #1;
    check_output({tag, " lat2 valid"}, 32'(b_ovalid), 32'd0);
    tick();
    #1;
    check_output({tag, " valid"}, 32'(b_ovalid), 32'd1);
    check_output({tag, " result"}, 32'(b_res), 32'(er));
    check_output({tag, " cout"}, 32'(b_cout), 32'(ec));
    tick();
    #1;
    check_output({tag, " drained"}, 32'(b_ovalid), 32'd0);
  endtask

  logic [15:0] opa [8];
  logic [15:0] opb [8];
  logic        opc [8];
  logic [16:0] exp_q [$];
  logic [16:0] held;
  int          sent, got, extra;
  logic        acc, seen;

  initial begin
    a_rst = 1'b1; a_valid = 1'b0; a_iready = 1'b1; a_t1 = '0; a_t2 = '0; a_cin = 1'b0;
    b_rst = 1'b1; b_valid = 1'b0; b_iready = 1'b1; b_t1 = '0; b_t2 = '0; b_cin = 1'b0;
    tick();
    #1;
    check_output("a ready in reset", 32'(a_oready), 32'd1);
    check_output("b ready in reset", 32'(b_oready), 32'd1);
    tick();
    a_rst = 1'b0; b_rst = 1'b0;
    #1;
    check_output("a reset valid", 32'(a_ovalid), 32'd0);
    check_output("a reset result", 32'(a_res), 32'd0);
    check_output("a reset cout", 32'(a_cout), 32'd0);
    check_output("b reset valid", 32'(b_ovalid), 32'd0);
    check_output("b reset result", 32'(b_res), 32'd0);
    check_output("a ready after reset", 32'(a_oready), 32'd1);

    $display("[TB] single operations, 16-bit S=2");
    apply_stimulus_a(16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, "a 1234+0fff");
    apply_stimulus_a(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, "a ffff+0+1");
    apply_stimulus_a(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, "a ffff+ffff+1");
    apply_stimulus_a(16'h8421, 16'h7BDE, 1'b1, 16'h0000, 1'b1, 1'b0, "a 8421+7bde+1");
    apply_stimulus_a(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "a 7fff+1");
    apply_stimulus_a(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "a ffff+1");
    apply_stimulus_a(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, "a 8000+8000");

    $display("[TB] single operations, 10-bit S=3");
    apply_stimulus_b(10'h3FF, 10'h001, 1'b0, 10'h000, 1'b1, "b 3ff+1");
    apply_stimulus_b(10'h2AA, 10'h155, 1'b1, 10'h000, 1'b1, "b 2aa+155+1");
    apply_stimulus_b(10'h123, 10'h0F0, 1'b0, 10'h213, 1'b0, "b 123+0f0");
    apply_stimulus_b(10'h200, 10'h300, 1'b0, 10'h100, 1'b1, "b 200+300");

    $display("[TB] streaming with a 3-cycle downstream stall");
    for (int i = 0; i < 8; i++) begin
      opa[i] = 16'($urandom);
      opb[i] = 16'($urandom);
      opc[i] = 1'($urandom);
    end
    sent = 0; got = 0; extra = 0; held = '0;
    exp_q.delete();
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      a_valid = (sent < 8);
      if (sent < 8) begin
        a_t1 = opa[sent]; a_t2 = opb[sent]; a_cin = opc[sent];
      end
      a_iready = !(cyc >= 4 && cyc <= 6);
      #1;
      if (cyc >= 4 && cyc <= 6) begin
        check_output("stall ready", 32'(a_oready), 32'd0);
        if (cyc == 4) held = {a_cout, a_res};
        else check_output("stall hold", 32'({a_cout, a_res}), 32'(held));
      end
      if (a_ovalid && a_iready) begin
        if (exp_q.size() > 0) check_output("stream result", 32'({a_cout, a_res}), 32'(exp_q.pop_front()));
        else extra++;
        got++;
      end
      acc = a_valid && a_oready;
      tick();
      if (acc) begin
        exp_q.push_back({1'b0, opa[sent]} + {1'b0, opb[sent]} + 17'(opc[sent]));
        sent++;
      end
    end
    a_valid = 1'b0; a_iready = 1'b1;
    check_output("stream count", 32'(got), 32'd8);
    check_output("stream sent", 32'(sent), 32'd8);
    check_output("stream extra", 32'(extra), 32'd0);
    check_output("stream leftover", 32'(exp_q.size()), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      seen = seen | a_ovalid;
      tick();
    end
    check_output("stream no repeat", 32'(seen), 32'd0);

    $display("[TB] reset with two operations in flight");
    b_iready = 1'b1; b_valid = 1'b1; b_t1 = 10'h111; b_t2 = 10'h222; b_cin = 1'b0;
    tick();
    b_t1 = 10'h0AA; b_t2 = 10'h055; b_cin = 1'b1;
    tick();
    b_rst = 1'b1; b_t1 = 10'h001; b_t2 = 10'h002; b_cin = 1'b0;
    #1;
    check_output("b flight valid", 32'(b_ovalid), 32'd0);
    check_output("b ready during reset", 32'(b_oready), 32'd1);
    tick();
    b_rst = 1'b0; b_valid = 1'b0;
    #1;
    check_output("b post-reset valid", 32'(b_ovalid), 32'd0);
    check_output("b post-reset result", 32'(b_res), 32'd0);
    check_output("b post-reset cout", 32'(b_cout), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      #1;
      seen = seen | b_ovalid;
    end
    check_output("b flushed ops never appear", 32'(seen), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
